rvfi_commit_serializer: RTL and testbench
=========================================

RVFI_COMMIT_SERIALIZER -- requirements
Module: rvfi_commit_serializer

Interface
- REQ-001 SHALL have parameter NR_COMMIT_PORTS, default 2: number of RVFI commit ports sampled per cycle.
- REQ-002 SHALL have parameter DEPTH, default 16: FIFO entries; power of two, minimum 4 (>= 2*NR_COMMIT_PORTS at default).
- REQ-003 SHALL have parameter HART_ID, 8 bits, default 0: reserved for downstream tagging; no functional effect.
- REQ-004 SHALL have port clk_i, input, 1: the single clock.
- REQ-005 SHALL have port rst_ni, input, 1: reset, asynchronous, active-low.
- REQ-006 SHALL have port rvfi_i, input, rvfi_pkg::rvfi_instr_t[NR_COMMIT_PORTS-1:0]: commit ports from core; cannot be stalled.
- REQ-007 SHALL have port rvfi_o, output, rvfi_pkg::rvfi_instr_t: head entry, one per cycle, to tracer.
- REQ-008 SHALL have port rvfi_valid_o, output, 1: rvfi_o holds a valid entry.
- REQ-009 SHALL have port rvfi_ready_i, input, 1: consumer accepts the head.
- REQ-010 SHALL have port overflow_o, output, 1: sticky; entries were dropped.
- REQ-011 SHALL have port instret_o, output, 64: retired-instruction count (stats feature).
- REQ-012 SHALL have port trap_cnt_o, output, 32: trap count (stats feature).

Function
- REQ-013 SHALL treat port i as an entry when rvfi_i[i].valid or rvfi_i[i].trap is 1; other ports are ignored.
- REQ-014 SHALL push all entries of a cycle in ascending port order, contiguously, with no gaps for idle ports.
- REQ-015 SHALL compute free space as DEPTH minus the occupancy at the start of the cycle; a same-cycle pop SHALL NOT add free space.
- REQ-016 SHALL push the lowest-index entries that fit when a cycle's entries exceed free space, drop the rest, and set overflow_o the next cycle.
- REQ-017 SHALL pop the head when rvfi_valid_o and rvfi_ready_i are both 1; rvfi_ready_i with an empty FIFO SHALL have no effect.
- REQ-018 SHALL present an entry pushed in cycle N on rvfi_o no earlier than cycle N+1, giving 1-cycle latency when empty.
- REQ-019 SHALL drive rvfi_o all-zero when rvfi_valid_o is 0.
- REQ-020 SHALL hold rvfi_o stable while rvfi_valid_o is 1 and rvfi_ready_i is 0.
- REQ-021 SHALL use read/write pointers of width $clog2(DEPTH) that wrap modulo DEPTH, plus an occupancy counter of width $clog2(DEPTH)+1.
- REQ-022 SHALL update occupancy as occupancy + pushed - popped, and SHALL keep it within 0..DEPTH under simultaneous push and pop.
- REQ-023 SHALL clear overflow_o only by reset.

Reset
- REQ-024 SHALL, while rst_ni is low, clear pointers, occupancy, overflow_o, instret_o and trap_cnt_o to 0, and drive rvfi_valid_o 0 and rvfi_o 0.
- REQ-025 SHALL discard buffered entries when reset asserts mid-operation; storage contents need not be cleared.

Configuration
- REQ-026 SHALL, with RVFI_COMMIT_SERIALIZER_STATS_EN defined, increment instret_o by the number of pushed entries with valid=1 and trap_cnt_o by the number with trap=1, counting at push and excluding dropped entries; both counters wrap.
- REQ-027 SHALL, without RVFI_COMMIT_SERIALIZER_STATS_EN, tie instret_o and trap_cnt_o to 0 and include no counter flops.

Structure
- REQ-028 SHALL take rvfi_instr_t from rvfi_pkg, and SHALL place the default FIFO depth constant RVFI_SER_DEPTH=16 there.
- REQ-029 SHALL implement compaction in one combinational sub-module, rvfi_port_compact; it outputs the compacted entries and an entry count.

Verification
- REQ-030 Bench: port0 valid (pc 0x80000000) and port1 valid (pc 0x80000004) in one cycle, ready=1 -> rvfi_o shows 0x80000000 in cycle N+1 and 0x80000004 in cycle N+2.
- REQ-031 Bench: port0 idle, port1 trap (pc 0x100) -> single entry with trap=1; trap_cnt_o=1 with the macro defined, 0 without.
- REQ-032 Bench: ready=0, DEPTH=16, 9 cycles of 2 valid entries -> 16 stored, 2 dropped, overflow_o=1; drained order matches push order.
- REQ-033 Bench: 15 entries stored, 2 pushed with a simultaneous pop -> port0 stored, port1 dropped, occupancy stays 15.
- REQ-034 Bench: rst_ni low for one cycle with 5 entries buffered -> rvfi_valid_o=0, occupancy 0 and overflow_o=0 at once; the next pushed entry appears first.
- REQ-035 Bench: 40 continuous entries with ready toggling 1/0, DEPTH=16 -> pointers wrap twice, no loss, no duplication, instret_o=40.

Source files
------------

// File: rtl/rvfi_pkg.sv
// RVFI record type shared by the commit serializer and its compaction stage,
// plus the default FIFO depth.
package rvfi_pkg;

  localparam int RVFI_SER_DEPTH = 16;

  typedef struct packed {
    logic        valid;
    logic [63:0] order;
    logic [31:0] insn;
    logic        trap;
    logic        halt;
    logic        intr;
    logic [1:0]  mode;
    logic [1:0]  ixl;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic [31:0] pc_rdata;
    logic [31:0] pc_wdata;
  } rvfi_instr_t;

  // A commit port carries an entry when it retires or traps.
  function automatic logic is_entry(rvfi_instr_t e);
    return e.valid | e.trap;
  endfunction

endpackage

// File: rtl/rvfi_port_compact.sv
// Packs the active commit ports of one cycle into the low slots, keeping
// ascending port order, and reports how many slots are used.
module rvfi_port_compact
  import rvfi_pkg::*;
#(
  parameter int NR_COMMIT_PORTS = 2,
  localparam int CNT_W = $clog2(NR_COMMIT_PORTS + 1)
) (
  input  rvfi_instr_t [NR_COMMIT_PORTS-1:0] ports_i,
  output rvfi_instr_t [NR_COMMIT_PORTS-1:0] entries_o,
  output logic [CNT_W-1:0]                  count_o
);

  // Each active port lands in the slot equal to the number of active ports below it.
  always_comb begin
    int unsigned pos;
    entries_o = '0;
    pos       = 0;
    for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
      if (is_entry(ports_i[i])) begin
        for (int j = 0; j < NR_COMMIT_PORTS; j++) begin
          if (pos == j) entries_o[j] = ports_i[i];
        end
        pos = pos + 1;
      end
    end
    count_o = CNT_W'(pos);
  end

endmodule

// File: rtl/rvfi_commit_serializer.sv
// Serializes several RVFI commit ports per cycle into one entry per cycle
// through a FIFO. Entries that do not fit are dropped and flagged sticky.
// Define RVFI_COMMIT_SERIALIZER_STATS_EN to enable the instret/trap counters.
module rvfi_commit_serializer
  import rvfi_pkg::*;
#(
  parameter int          NR_COMMIT_PORTS = 2,
  parameter int          DEPTH           = RVFI_SER_DEPTH,
  parameter logic [7:0]  HART_ID         = 8'd0
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  rvfi_instr_t [NR_COMMIT_PORTS-1:0] rvfi_i,
  output rvfi_instr_t                       rvfi_o,
  output logic                              rvfi_valid_o,
  input  logic                              rvfi_ready_i,
  output logic                              overflow_o,
  output logic [63:0]                       instret_o,
  output logic [31:0]                       trap_cnt_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ECW   = $clog2(NR_COMMIT_PORTS + 1);

  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 || $bits(HART_ID) != 8) begin : g_bad_cfg
    $error("rvfi_commit_serializer: DEPTH must be a power of two >= 4");
  end

  rvfi_instr_t [NR_COMMIT_PORTS-1:0] comp;
  logic [ECW-1:0]   comp_cnt;
  logic [CNT_W-1:0] free, push_n;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic             ovf_q, ovf_d;
  logic             pop;
  rvfi_instr_t      mem_q [DEPTH];

  rvfi_port_compact #(
    .NR_COMMIT_PORTS(NR_COMMIT_PORTS)
  ) u_compact (
    .ports_i  (rvfi_i),
    .entries_o(comp),
    .count_o  (comp_cnt)
  );

  // Admission limited to space free at cycle start; a same-cycle pop frees nothing.
  always_comb begin
    free   = CNT_W'(DEPTH) - cnt_q;
    push_n = (CNT_W'(comp_cnt) > free) ? free : CNT_W'(comp_cnt);
    pop    = (cnt_q != '0) && rvfi_ready_i;
    cnt_d  = cnt_q + push_n - CNT_W'(pop);
    wptr_d = wptr_q + PTR_W'(push_n);
    rptr_d = rptr_q + PTR_W'(pop);
    ovf_d  = ovf_q | (CNT_W'(comp_cnt) > free);
  end

  // Control state: pointers, occupancy and the sticky drop flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      ovf_q  <= ovf_d;
    end
  end

  // Storage writes admitted entries at consecutive wrapping slots; never reset.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < NR_COMMIT_PORTS; k++) begin
      if (CNT_W'(k) < push_n) mem_q[wptr_q + PTR_W'(k)] <= comp[k];
    end
  end

  assign rvfi_valid_o = (cnt_q != '0);
  assign rvfi_o       = rvfi_valid_o ? mem_q[rptr_q] : '0;
  assign overflow_o   = ovf_q;

`ifdef RVFI_COMMIT_SERIALIZER_STATS_EN
  logic [ECW-1:0] inc_instret, inc_trap;
  logic [63:0]    instret_q;
  logic [31:0]    trap_cnt_q;

  // Count retired and trapping entries among those actually admitted.
  always_comb begin
    inc_instret = '0;
    inc_trap    = '0;
    for (int k = 0; k < NR_COMMIT_PORTS; k++) begin
      if (CNT_W'(k) < push_n) begin
        inc_instret = inc_instret + ECW'(comp[k].valid);
        inc_trap    = inc_trap + ECW'(comp[k].trap);
      end
    end
  end

  // Wrapping statistics counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      instret_q  <= '0;
      trap_cnt_q <= '0;
    end else begin
      instret_q  <= instret_q + 64'(inc_instret);
      trap_cnt_q <= trap_cnt_q + 32'(inc_trap);
    end
  end

  assign instret_o  = instret_q;
  assign trap_cnt_o = trap_cnt_q;
`else
  assign instret_o  = '0;
  assign trap_cnt_o = '0;
`endif

endmodule

// File: tb/tb_rvfi_commit_serializer.sv
// Self-checking bench for rvfi_commit_serializer with a queue-based model.
module tb_rvfi_commit_serializer;
  import rvfi_pkg::*;

  localparam int NR    = 2;
  localparam int DEPTH = 16;
`ifdef RVFI_COMMIT_SERIALIZER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_ni = 1'b0;
  rvfi_instr_t [NR-1:0] rvfi_in = '0;
  rvfi_instr_t      rvfi_out;
  logic             rvfi_valid;
  logic             ready = 1'b0;
  logic             overflow;
  logic [63:0]      instret;
  logic [31:0]      trap_cnt;

  int checks = 0;
  int errors = 0;

  rvfi_instr_t mq[$];

  rvfi_commit_serializer #(
    .NR_COMMIT_PORTS(NR),
    .DEPTH(DEPTH),
    .HART_ID(8'd3)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .rvfi_i      (rvfi_in),
    .rvfi_o      (rvfi_out),
    .rvfi_valid_o(rvfi_valid),
    .rvfi_ready_i(ready),
    .overflow_o  (overflow),
    .instret_o   (instret),
    .trap_cnt_o  (trap_cnt)
  );

  always #5 clk = ~clk;

  // Reference: a FIFO of whole records; admission bounded by pre-pop free space.
  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      mq.delete();
    end else begin
      int free;
      free = DEPTH - mq.size();
      if (mq.size() > 0 && ready) void'(mq.pop_front());
      for (int i = 0; i < NR; i++) begin
        if ((rvfi_in[i].valid || rvfi_in[i].trap) && free > 0) begin
          mq.push_back(rvfi_in[i]);
          free--;
        end
      end
    end
  end

  function automatic rvfi_instr_t mhead();
    rvfi_instr_t h;
    h = '0;
    if (mq.size() != 0) h = mq[0];
    return h;
  endfunction

  function automatic rvfi_instr_t mk(logic v, logic t, logic [31:0] pc);
    rvfi_instr_t e;
    e          = '0;
    e.valid    = v;
    e.trap     = t;
    e.pc_rdata = pc;
    e.pc_wdata = pc + 32'd4;
    e.insn     = $urandom;
    e.order    = {$urandom, $urandom};
    e.rd_addr  = 5'($urandom);
    e.rd_wdata = $urandom;
    return e;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_ni  = 1'b0;
    rvfi_in = '0;
    ready   = 1'b0;
    @(negedge clk);
    rst_ni  = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (rvfi_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", rvfi_valid); end
    checks++; if (rvfi_out !== '0) begin errors++; $display("FAIL reset_data: got %h expected 0", rvfi_out); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    checks++; if (instret !== 64'd0) begin errors++; $display("FAIL reset_instret: got %0d expected 0", instret); end
    checks++; if (trap_cnt !== 32'd0) begin errors++; $display("FAIL reset_trapcnt: got %0d expected 0", trap_cnt); end
    rst_ni = 1'b1;
  endtask

  task automatic test_pair();
    rvfi_instr_t e0, e1;
    @(negedge clk);
    e0 = mk(1'b1, 1'b0, 32'h8000_0000);
    e1 = mk(1'b1, 1'b0, 32'h8000_0004);
    rvfi_in[0] = e0; rvfi_in[1] = e1; ready = 1'b1;
    @(negedge clk);
    rvfi_in = '0;
    checks++; if (rvfi_valid !== 1'b1) begin errors++; $display("FAIL pair_valid1: got %b expected 1", rvfi_valid); end
    checks++; if (rvfi_out.pc_rdata !== 32'h8000_0000) begin errors++; $display("FAIL pair_pc1: got %h expected 80000000", rvfi_out.pc_rdata); end
    checks++; if (rvfi_out !== e0) begin errors++; $display("FAIL pair_rec1: got %h expected %h", rvfi_out, e0); end
    @(negedge clk);
    checks++; if (rvfi_out.pc_rdata !== 32'h8000_0004 || rvfi_out !== e1) begin errors++; $display("FAIL pair_rec2: got pc %h expected 80000004", rvfi_out.pc_rdata); end
    @(negedge clk);
    checks++; if (rvfi_valid !== 1'b0 || rvfi_out !== '0) begin errors++; $display("FAIL pair_empty: got valid %b data %h expected 0/0", rvfi_valid, rvfi_out); end
  endtask

  task automatic test_trap();
    rvfi_instr_t e;
    @(negedge clk);
    e = mk(1'b0, 1'b1, 32'h0000_0100);
    rvfi_in[0] = '0; rvfi_in[1] = e;
    @(negedge clk);
    rvfi_in = '0;
    checks++; if (rvfi_valid !== 1'b1 || rvfi_out !== e) begin errors++; $display("FAIL trap_rec: got pc %h valid %b expected pc 100", rvfi_out.pc_rdata, rvfi_valid); end
    checks++; if (rvfi_out.trap !== 1'b1) begin errors++; $display("FAIL trap_bit: got %b expected 1", rvfi_out.trap); end
    checks++; if (trap_cnt !== (STATS ? 32'd1 : 32'd0)) begin errors++; $display("FAIL trap_cnt: got %0d expected %0d", trap_cnt, STATS ? 1 : 0); end
    checks++; if (instret !== (STATS ? 64'd2 : 64'd0)) begin errors++; $display("FAIL trap_instret: got %0d expected %0d", instret, STATS ? 2 : 0); end
    @(negedge clk);
    checks++; if (rvfi_valid !== 1'b0) begin errors++; $display("FAIL trap_single: got valid %b expected 0", rvfi_valid); end
  endtask

  task automatic test_overflow();
    rvfi_instr_t exp[$];
    rvfi_instr_t a, b;
    do_reset();
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      if (c == 8) begin
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b expected 0 at 16 stored", overflow); end
      end
      a = mk(1'b1, 1'b0, $urandom); b = mk(1'b1, 1'b0, $urandom);
      rvfi_in[0] = a; rvfi_in[1] = b;
      exp.push_back(a); exp.push_back(b);
    end
    @(negedge clk);
    rvfi_in = '0;
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", overflow); end
    checks++; if (rvfi_valid !== 1'b1 || rvfi_out !== exp[0]) begin errors++; $display("FAIL ovf_head: got pc %h expected %h", rvfi_out.pc_rdata, exp[0].pc_rdata); end
    @(negedge clk);
    checks++; if (rvfi_out !== exp[0]) begin errors++; $display("FAIL ovf_hold: got pc %h expected %h", rvfi_out.pc_rdata, exp[0].pc_rdata); end
    ready = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      checks++; if (rvfi_valid !== 1'b1 || rvfi_out !== exp[k]) begin errors++; $display("FAIL ovf_drain%0d: got pc %h expected %h", k, rvfi_out.pc_rdata, exp[k].pc_rdata); end
      @(negedge clk);
    end
    checks++; if (rvfi_valid !== 1'b0) begin errors++; $display("FAIL ovf_dropped: got valid %b expected 0 (pc %h)", rvfi_valid, rvfi_out.pc_rdata); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
  endtask

  task automatic test_simul_pop();
    rvfi_instr_t exp[$];
    rvfi_instr_t a, b;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      a = mk(1'b1, 1'b0, $urandom); b = mk(1'b1, 1'b0, $urandom);
      if (c == 7) begin
        rvfi_in[0] = '0; rvfi_in[1] = b; exp.push_back(b);
      end else begin
        rvfi_in[0] = a; rvfi_in[1] = b; exp.push_back(a); exp.push_back(b);
      end
    end
    @(negedge clk);
    checks++; if (rvfi_out !== exp[0]) begin errors++; $display("FAIL sp_head: got pc %h expected %h", rvfi_out.pc_rdata, exp[0].pc_rdata); end
    a = mk(1'b1, 1'b0, 32'hA000_0000); b = mk(1'b1, 1'b0, 32'hB000_0000);
    rvfi_in[0] = a; rvfi_in[1] = b; ready = 1'b1;
    exp.push_back(a);
    @(negedge clk);
    rvfi_in = '0;
    for (int k = 1; k <= 15; k++) begin
      checks++; if (rvfi_valid !== 1'b1 || rvfi_out !== exp[k]) begin errors++; $display("FAIL sp_drain%0d: got pc %h expected %h", k, rvfi_out.pc_rdata, exp[k].pc_rdata); end
      @(negedge clk);
    end
    checks++; if (rvfi_valid !== 1'b0) begin errors++; $display("FAIL sp_occupancy: got valid %b expected 0 after 15 pops", rvfi_valid); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL sp_overflow: got %b expected 1", overflow); end
  endtask

  task automatic test_reset_mid();
    rvfi_instr_t x;
    ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      rvfi_in[0] = mk(1'b1, 1'b0, $urandom);
      rvfi_in[1] = (c < 2) ? mk(1'b1, 1'b0, $urandom) : '0;
    end
    @(negedge clk);
    rvfi_in = '0;
    checks++; if (rvfi_valid !== 1'b1 || overflow !== 1'b1) begin errors++; $display("FAIL rm_pre: got valid %b ovf %b expected 1/1", rvfi_valid, overflow); end
    #2 rst_ni = 1'b0;
    #1;
    checks++; if (rvfi_valid !== 1'b0 || rvfi_out !== '0) begin errors++; $display("FAIL rm_valid: got valid %b data %h expected 0/0", rvfi_valid, rvfi_out); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rm_overflow: got %b expected 0", overflow); end
    checks++; if (instret !== 64'd0 || trap_cnt !== 32'd0) begin errors++; $display("FAIL rm_stats: got %0d/%0d expected 0/0", instret, trap_cnt); end
    @(negedge clk);
    rst_ni = 1'b1;
    x = mk(1'b1, 1'b0, 32'hC0DE_0000);
    rvfi_in[0] = x; ready = 1'b1;
    @(negedge clk);
    rvfi_in = '0;
    checks++; if (rvfi_valid !== 1'b1 || rvfi_out !== x) begin errors++; $display("FAIL rm_first: got pc %h expected c0de0000", rvfi_out.pc_rdata); end
    @(negedge clk);
    checks++; if (rvfi_valid !== 1'b0) begin errors++; $display("FAIL rm_stale: got valid %b pc %h expected 0", rvfi_valid, rvfi_out.pc_rdata); end
  endtask

  task automatic test_wrap();
    rvfi_instr_t sent[$];
    rvfi_instr_t got[$];
    int cyc, bad, n, free;
    do_reset();
    cyc = 0;
    while ((sent.size() < 40 || mq.size() != 0) && cyc < 400) begin
      @(negedge clk);
      cyc++;
      ready = cyc[0];
      checks++; if (rvfi_valid !== (mq.size() != 0) || rvfi_out !== mhead()) begin errors++; $display("FAIL wrap_head c%0d: got valid %b pc %h expected pc %h", cyc, rvfi_valid, rvfi_out.pc_rdata, mhead().pc_rdata); end
      if (rvfi_valid && ready) got.push_back(rvfi_out);
      rvfi_in = '0;
      free = DEPTH - mq.size();
      n = $urandom_range(2, 0);
      if (n > 40 - sent.size()) n = 40 - sent.size();
      if (n > free) n = free;
      if (n == 2) begin
        rvfi_in[0] = mk(1'b1, 1'b0, $urandom); rvfi_in[1] = mk(1'b1, 1'b0, $urandom);
        sent.push_back(rvfi_in[0]); sent.push_back(rvfi_in[1]);
      end else if (n == 1) begin
        if ($urandom_range(1, 0) == 1) begin
          rvfi_in[1] = mk(1'b1, 1'b0, $urandom); sent.push_back(rvfi_in[1]);
        end else begin
          rvfi_in[0] = mk(1'b1, 1'b0, $urandom); sent.push_back(rvfi_in[0]);
        end
      end
    end
    @(negedge clk);
    checks++; if (cyc >= 400) begin errors++; $display("FAIL wrap_timeout: got %0d cycles expected < 400", cyc); end
    checks++; if (got.size() !== 40) begin errors++; $display("FAIL wrap_count: got %0d entries expected 40", got.size()); end
    bad = 0;
    for (int k = 0; k < 40 && k < got.size(); k++) if (got[k] !== sent[k]) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL wrap_order: got %0d mismatching entries expected 0", bad); end
    checks++; if (instret !== (STATS ? 64'd40 : 64'd0)) begin errors++; $display("FAIL wrap_instret: got %0d expected %0d", instret, STATS ? 40 : 0); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL wrap_overflow: got %b expected 0", overflow); end
  endtask

  initial begin
    test_reset();
    test_pair();
    test_trap();
    test_overflow();
    test_simul_pop();
    test_reset_mid();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
